dmem_arbiter: RTL

- Sequences and shares the byte-addressed data RAM between two requesters: port 0 (CPU load/store) and port 1 (debug/loader).
- Per request it:
  - arbitrates round-robin;
  - checks type, alignment and data-memory range;
  - splits halfword stores into two byte writes, because the RAM write path supports only word and byte;
  - applies optional zero-extension to loads;
  - returns a registered response.
- Sits between the core's memory stage / debug loader and the RAM.

---
 rtl/dmem_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the byte-addressed data RAM between
// the CPU load/store port (0) and the debug/loader port (1). Each request is
// validated (type, alignment, range), halfword stores are split into two byte
// writes, loads can be zero-extended, and a registered response is returned.
module dmem_arbiter #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] DMEM_BASE  = 32'h0000_1000,
   parameter logic [ADDR_WIDTH-1:0] DMEM_SIZE  = 32'h0000_1000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [1:0]              req_we,
   input  logic [3:0]              req_type,
   input  logic [1:0]              req_uns,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              rsp_valid,
   input  logic [1:0]              rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    mem_we,
   output logic [1:0]              mem_type,
   output logic [ADDR_WIDTH-1:0]   mem_a,
   output logic [DATA_WIDTH-1:0]   mem_wd,
   input  logic [DATA_WIDTH-1:0]   mem_rd,
   output logic                    busy
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   localparam logic [1:0] T_WORD = 2'b00;
   localparam logic [1:0] T_BYTE = 2'b01;
   localparam logic [1:0] T_HALF = 2'b10;
   localparam logic [1:0] T_ILL  = 2'b11;

   // Range limits carried one bit wider so an address near the top of the
   // address space cannot wrap around into the legal window.
   localparam logic [ADDR_WIDTH:0] LIM_LO = {1'b0, DMEM_BASE};
   localparam logic [ADDR_WIDTH:0] LIM_HI = {1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE}
                                            - {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                  state;
   logic                    last_grant;
   logic                    owner;
   logic                    l_we;
   logic [1:0]              l_type;
   logic                    l_uns;
   logic [ADDR_WIDTH-1:0]   l_addr;
   logic [7:0]              l_hi;

   logic                    win;
   logic                    grant;
   logic                    w_we;
   logic [1:0]              w_type;
   logic                    w_uns;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic [DATA_WIDTH-1:0]   w_wdata;
   logic [ADDR_WIDTH:0]     w_last;
   logic [ADDR_WIDTH:0]     nbytes_m1;
   logic                    w_err;

   // Place a byte in the low lane of a RAM write word.
   function automatic logic [DATA_WIDTH-1:0] zext8(input logic [7:0] b);
      return {{(DATA_WIDTH-8){1'b0}}, b};
   endfunction

   // Apply optional zero-extension to the RAM's sign-extended read data.
   function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [DATA_WIDTH-1:0] rd,
                                                      input logic [1:0] typ,
                                                      input logic uns);
      logic [DATA_WIDTH-1:0] r;
      r = rd;
      if (uns && typ == T_BYTE) r = {{(DATA_WIDTH-8){1'b0}}, rd[7:0]};
      if (uns && typ == T_HALF) r = {{(DATA_WIDTH-16){1'b0}}, rd[15:0]};
      return r;
   endfunction

   // Winner selection: a lone requester wins, contention goes to the port
   // that was not granted last.
   always_comb begin
      win = 1'b0;
      case (req_valid)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         2'b11:   win = ~last_grant;
         default: win = 1'b0;
      endcase
   end

   assign grant     = (state == IDLE) && (req_valid != 2'b00);
   assign req_ready = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
   assign busy      = (state != IDLE);

   // Mux the winning port's request fields and classify it as legal or not.
   always_comb begin
      w_we      = win ? req_we[1]   : req_we[0];
      w_type    = win ? req_type[3:2] : req_type[1:0];
      w_uns     = win ? req_uns[1]  : req_uns[0];
      w_addr    = win ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]   : req_addr[0 +: ADDR_WIDTH];
      w_wdata   = win ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];
      nbytes_m1 = '0;
      case (w_type)
         T_WORD:  nbytes_m1 = {{(ADDR_WIDTH-1){1'b0}}, 2'd3};
         T_HALF:  nbytes_m1 = {{(ADDR_WIDTH-1){1'b0}}, 2'd1};
         default: nbytes_m1 = '0;
      endcase
      w_last = {1'b0, w_addr} + nbytes_m1;
      w_err  = (w_type == T_ILL)
             | ((w_type == T_WORD) && (w_addr[1:0] != 2'b00))
             | ((w_type == T_HALF) && w_addr[0])
             | ({1'b0, w_addr} < LIM_LO)
             | (w_last > LIM_HI);
   end

   // Access sequencer: accept, drive the RAM for one or two cycles, then hold
   // the response until the owning port consumes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         l_we       <= 1'b0;
         l_type     <= T_WORD;
         l_uns      <= 1'b0;
         l_addr     <= '0;
         l_hi       <= '0;
         rsp_valid  <= 2'b00;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         mem_we     <= 1'b0;
         mem_type   <= T_WORD;
         mem_a      <= '0;
         mem_wd     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  last_grant <= win;
                  owner      <= win;
                  l_we       <= w_we;
                  l_type     <= w_type;
                  l_uns      <= w_uns;
                  l_addr     <= w_addr;
                  l_hi       <= w_wdata[15:8];
                  rsp_rdata  <= '0;
                  rsp_err    <= w_err;
                  if (w_err) begin
                     state     <= RESP;
                     rsp_valid <= win ? 2'b10 : 2'b01;
                  end else begin
                     // Outputs are registered, so the first RAM cycle is set up here.
                     state    <= ACC0;
                     mem_a    <= w_addr;
                     mem_we   <= w_we;
                     mem_type <= (w_we && w_type == T_HALF) ? T_BYTE : w_type;
                     if (w_we)
                        mem_wd <= (w_type == T_WORD) ? w_wdata : zext8(w_wdata[7:0]);
                  end
               end
            end
            ACC0: begin
               if (l_we && l_type == T_HALF) begin
                  state  <= ACC1;
                  mem_a  <= l_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                  mem_wd <= zext8(l_hi);
               end else begin
                  state     <= RESP;
                  mem_we    <= 1'b0;
                  rsp_valid <= owner ? 2'b10 : 2'b01;
                  if (!l_we)
                     rsp_rdata <= load_ext(mem_rd, l_type, l_uns);
               end
            end
            ACC1: begin
               state     <= RESP;
               mem_we    <= 1'b0;
               rsp_valid <= owner ? 2'b10 : 2'b01;
            end
            RESP: begin
               if (rsp_ready[owner]) begin
                  state     <= IDLE;
                  rsp_valid <= 2'b00;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
